// File: rtl/target_scheduler_if.sv
// Round-control bundle between the reaction-game sequencer and its pads, LEDs and score logic.
interface target_scheduler_if #(
  parameter int MAX_VALUE = 16
);
  logic                         start;
  logic [$clog2(MAX_VALUE)-1:0] rand_value;
  logic [MAX_VALUE-1:0]         hit_in;
  logic [MAX_VALUE-1:0]         target_led;
  logic                         busy;
  logic                         hit_pulse;
  logic                         miss_pulse;
  logic [10:0]                  reaction_ms;

  modport master (
    output start, rand_value, hit_in,
    input  target_led, busy, hit_pulse, miss_pulse, reaction_ms
  );

  modport slave (
    input  start, rand_value, hit_in,
    output target_led, busy, hit_pulse, miss_pulse, reaction_ms
  );
endinterface

// File: rtl/target_scheduler.sv
// Reaction-game round sequencer: random delay, one random LED, ms reaction timing, 1-cycle hit/miss pulse.
// All outputs registered, pad response 1 cycle; no backpressure. TARGET_NO_REPEAT_EN forbids consecutive repeated targets.
module target_scheduler #(
  parameter int MAX_VALUE     = 16,
  parameter int CLKS_PER_MS   = 50000,
  parameter int BASE_DELAY_MS = 200,
  parameter int DELAY_SHIFT   = 6,
  parameter int TIMEOUT_MS    = 1000
) (
  input  logic               clk,
  input  logic               reset,
  target_scheduler_if.slave  bus
);

  localparam int IW = $clog2(MAX_VALUE);
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, RESULT} state_t;

  state_t               state;
  logic [PW-1:0]        presc;
  logic [10:0]          ms_cnt;
  logic [10:0]          delay_ms;
  logic [MAX_VALUE-1:0] target_led;
  logic                 busy;
  logic                 hit_pulse;
  logic                 miss_pulse;
  logic [10:0]          reaction_ms;
  logic [IW-1:0]        cap_idx;
  logic                 tick;
  logic                 delay_end;

  assign tick      = (presc == PW'(CLKS_PER_MS - 1));
  assign delay_end = (ms_cnt == delay_ms - 11'd1);

`ifdef TARGET_NO_REPEAT_EN
  logic [IW-1:0] last_idx;

  // A repeat of the previous target is bumped to the next index, wrapping at MAX_VALUE.
  always_comb begin
    cap_idx = bus.rand_value;
    if (bus.rand_value == last_idx)
      cap_idx = (last_idx == IW'(MAX_VALUE - 1)) ? '0 : bus.rand_value + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_idx <= '0;
    else if (state == DELAY && tick && delay_end)
      last_idx <= cap_idx;
  end
`else
  assign cap_idx = bus.rand_value;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      ms_cnt      <= '0;
      delay_ms    <= '0;
      target_led  <= '0;
      busy        <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      reaction_ms <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            delay_ms    <= 11'(BASE_DELAY_MS) + (11'(bus.rand_value) << DELAY_SHIFT);
            presc       <= '0;
            ms_cnt      <= '0;
            reaction_ms <= '0;
            busy        <= 1'b1;
            state       <= DELAY;
          end
        end
        DELAY: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (delay_end) begin
              target_led <= MAX_VALUE'(1) << cap_idx;
              ms_cnt     <= '0;
              state      <= ACTIVE;
            end else begin
              ms_cnt <= ms_cnt + 11'd1;
            end
          end
        end
        ACTIVE: begin
          presc <= tick ? '0 : presc + PW'(1);
          // A correct pad wins even when wrong pads are pressed alongside it.
          if (|(bus.hit_in & target_led)) begin
            hit_pulse   <= 1'b1;
            reaction_ms <= ms_cnt;
            target_led  <= '0;
            state       <= RESULT;
          end else if (|bus.hit_in) begin
            miss_pulse  <= 1'b1;
            reaction_ms <= ms_cnt;
            target_led  <= '0;
            state       <= RESULT;
          end else if (tick) begin
            if (ms_cnt + 11'd1 == 11'(TIMEOUT_MS)) begin
              miss_pulse  <= 1'b1;
              reaction_ms <= 11'(TIMEOUT_MS);
              target_led  <= '0;
              state       <= RESULT;
            end else begin
              ms_cnt <= ms_cnt + 11'd1;
            end
          end
        end
        RESULT: begin
          if (bus.hit_in == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.target_led  = target_led;
  assign bus.busy        = busy;
  assign bus.hit_pulse   = hit_pulse;
  assign bus.miss_pulse  = miss_pulse;
  assign bus.reaction_ms = reaction_ms;

endmodule

// File: tb/tb_target_scheduler.sv
// Scoreboard bench for target_scheduler with 4 clocks per ms, 2 ms base delay, shift 1, 10 ms timeout.
module tb_target_scheduler;

`ifdef TARGET_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  target_scheduler_if #(.MAX_VALUE(16)) bus();

  target_scheduler #(
    .MAX_VALUE(16), .CLKS_PER_MS(4), .BASE_DELAY_MS(2), .DELAY_SHIFT(1), .TIMEOUT_MS(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        hit;
    logic [10:0] react;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_last = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected target index for a captured random value.
  function automatic logic [3:0] pick(input logic [3:0] rv);
    return (NO_REPEAT && rv == model_last) ? rv + 4'd1 : rv;
  endfunction

  // Monitor: every pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.hit_pulse || bus.miss_pulse)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b with nothing queued", bus.hit_pulse, bus.miss_pulse);
      end else begin
        e = sb.pop_front();
        check("pulse_hit", bus.hit_pulse, e.hit);
        check("pulse_miss", bus.miss_pulse, !e.hit);
        check("pulse_reaction_ms", bus.reaction_ms, e.react);
        check("pulse_led_cleared", bus.target_led, 0);
      end
    end
  end

  // press_ticks < 0 means no press (timeout round).
  task automatic run_round(input logic [3:0] rv0, input logic [3:0] rv1, input int press_ticks,
                           input logic hit_target, input logic [15:0] extra, input logic hold_start);
    int          delay;
    int          n;
    logic [3:0]  idx;
    logic [15:0] led;
    exp_t        e;
    idx        = pick(rv1);
    model_last = idx;
    led        = 16'h0001 << idx;
    delay      = 2 + 2 * int'(rv0);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.rand_value = rv0;
    @(negedge clk);
    bus.start      = hold_start;
    bus.rand_value = rv1;
    check("busy_after_start", bus.busy, 1);
    check("reaction_cleared", bus.reaction_ms, 0);
    repeat (delay * 4 - 1) @(negedge clk);
    check("led_before_delay", bus.target_led, 0);
    @(negedge clk);
    check("led_lit", bus.target_led, led);
    if (press_ticks >= 0) begin
      repeat (press_ticks * 4) @(negedge clk);
      bus.hit_in = (hit_target ? led : 16'h0000) | extra;
      e.hit   = hit_target;
      e.react = 11'(press_ticks);
      sb.push_back(e);
      repeat (2) @(negedge clk);
      check("single_pulse", {bus.hit_pulse, bus.miss_pulse}, 0);
      repeat (8) @(negedge clk);
      check("held_in_result", bus.busy, 1);
      bus.hit_in = 16'h0000;
    end else begin
      e.hit   = 1'b0;
      e.react = 11'd10;
      sb.push_back(e);
      repeat (39) @(negedge clk);
      check("no_early_timeout", bus.miss_pulse, 0);
      bus.start = 1'b0;
    end
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("back_to_idle", bus.busy, 0);
    check("reaction_held", bus.reaction_ms, e.react);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.rand_value = 4'd0;
    bus.hit_in     = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_state", {bus.target_led, bus.busy, bus.hit_pulse, bus.miss_pulse, bus.reaction_ms}, 0);
    reset = 1'b0;

    run_round(4'd3, 4'd5, 3, 1'b1, 16'h0000, 1'b0);   // delay 8 ms, target 5, hit at 3 ms
    run_round(4'd0, 4'd5, 1, 1'b1, 16'h0004, 1'b0);   // target plus pad 2 together
    run_round(4'd1, 4'd5, 2, 1'b0, 16'h0004, 1'b0);   // pad 2 alone
    run_round(4'd1, 4'd9, -1, 1'b0, 16'h0000, 1'b1);  // timeout with start held
    run_round(4'd2, 4'd7, 0, 1'b1, 16'h0000, 1'b0);   // immediate hit, reaction 0
    run_round(4'd0, 4'd7, 4, 1'b1, 16'h0000, 1'b0);   // repeated 7
    run_round(4'd0, 4'd15, 1, 1'b1, 16'h0000, 1'b0);
    run_round(4'd0, 4'd15, 2, 1'b1, 16'h0000, 1'b0);  // repeated 15 wraps to 0

    // Reset in the middle of an active round.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.rand_value = 4'd0;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.rand_value = 4'd3;
    repeat (8) @(negedge clk);
    check("reset_round_led", bus.target_led, 16'h0001 << pick(4'd3));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {bus.target_led, bus.busy, bus.hit_pulse, bus.miss_pulse, bus.reaction_ms}, 0);
    model_last = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_round(4'd2, 4'd3, 2, 1'b1, 16'h0000, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
